// File: rtl/cfifo_param.sv
// cfifo_param: DEPTH-stage synchronous click-style elastic FIFO with drive/free pulse handshakes,
// programmable output delay, occupancy and sticky protocol-error flags.
module cfifo_param #(
   parameter int DEPTH     = 4,
   parameter int WIDTH     = 8,
   parameter int OUT_DELAY = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         i_drive,
   input  logic [WIDTH-1:0]             i_data,
   output logic                         o_free,
   output logic                         o_driveNext,
   output logic [WIDTH-1:0]             o_data,
   input  logic                         i_freeNext,
   output logic [DEPTH-1:0]             o_fire,
   output logic [$clog2(DEPTH+1)-1:0]   o_count,
   output logic                         o_overflow,
   output logic                         o_underflow
);
   localparam int L = DEPTH - 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [2:0] DLY = 3'(OUT_DELAY);
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_OFFERED} state_t;
   state_t st, st_n;
   logic [2:0] cnt, cnt_n;
   logic [DEPTH-1:0] full, load, unload;
   logic [WIDTH-1:0] d [DEPTH];
   logic cap, offered, take;
   assign cap = i_drive & ~full[0];
   assign offered = (st == S_WAIT && cnt == '0) || st == S_OFFERED;
   assign take = i_freeNext & offered;
   assign o_data = d[L];
   // Hops use only registered full bits, so a freed stage refills one edge later at the earliest.
   always_comb begin
      load = '0;
      unload = '0;
      load[0] = cap;
      for (int k = 0; k < L; k++) begin
         load[k+1] = full[k] & ~full[k+1];
         unload[k] = full[k] & ~full[k+1];
      end
      unload[L] = take;
   end
   always_comb begin
      st_n = st;
      cnt_n = cnt;
      if (st == S_IDLE) begin
         if (load[L]) begin
            st_n = S_WAIT;
            cnt_n = DLY;
         end
      end else if (take) begin
         st_n = S_IDLE;
      end else if (st == S_WAIT) begin
         if (cnt == '0) st_n = S_OFFERED;
         else cnt_n = cnt - 3'd1;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         full <= '0;
         for (int k = 0; k < DEPTH; k++) d[k] <= '0;
         st <= S_IDLE;
         cnt <= '0;
         o_fire <= '0;
         o_free <= 1'b0;
         o_driveNext <= 1'b0;
         o_count <= '0;
         o_overflow <= 1'b0;
         o_underflow <= 1'b0;
      end else begin
         full <= (full | load) & ~unload;
         if (load[0]) d[0] <= i_data;
         for (int k = 1; k < DEPTH; k++) if (load[k]) d[k] <= d[k-1];
         st <= st_n;
         cnt <= cnt_n;
         o_fire <= load;
         o_free <= unload[0];
         o_driveNext <= st_n == S_WAIT && cnt_n == '0;
         o_count <= o_count + CW'(cap) - CW'(take);
         o_overflow <= o_overflow | (i_drive & full[0]);
         o_underflow <= o_underflow | (i_freeNext & ~offered);
      end
   end
endmodule

// File: tb/tb_cfifo_param.sv
// tb_cfifo_param: directed protocol scenarios plus a randomized well-behaved run checked
// against a queue model of accepted tokens.
module tb_cfifo_param;
   logic clk = 0, rst = 1;
   logic i_drive = 0, i_freeNext = 0;
   logic [7:0] i_data = 0;
   logic o_free, o_driveNext, o_overflow, o_underflow;
   logic [7:0] o_data;
   logic [3:0] o_fire;
   logic [2:0] o_count;
   logic d1 = 0, f1 = 0;
   logic [7:0] v1 = 0;
   logic g_free, g_drv, g_ovf, g_unf;
   logic [7:0] g_data;
   logic [0:0] g_fire, g_count;
   int total = 0, bad = 0;
   logic [7:0] q[$];
   logic [7:0] vals[4] = '{8'h11, 8'h22, 8'h33, 8'h44};

   cfifo_param #(.DEPTH(4), .WIDTH(8), .OUT_DELAY(2)) dut (
      .clk(clk), .rst(rst), .i_drive(i_drive), .i_data(i_data), .o_free(o_free),
      .o_driveNext(o_driveNext), .o_data(o_data), .i_freeNext(i_freeNext), .o_fire(o_fire),
      .o_count(o_count), .o_overflow(o_overflow), .o_underflow(o_underflow));

   cfifo_param #(.DEPTH(1), .WIDTH(8), .OUT_DELAY(0)) dut1 (
      .clk(clk), .rst(rst), .i_drive(d1), .i_data(v1), .o_free(g_free),
      .o_driveNext(g_drv), .o_data(g_data), .i_freeNext(f1), .o_fire(g_fire),
      .o_count(g_count), .o_overflow(g_ovf), .o_underflow(g_unf));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Inputs apply for one cycle; returns at the negedge of the following cycle.
   task automatic go(input logic dv, input logic [7:0] v, input logic fr);
      i_drive = dv;
      i_data = v;
      i_freeNext = fr;
      @(negedge clk);
      i_drive = 0;
      i_freeNext = 0;
   endtask

   task automatic do_reset();
      rst = 1;
      @(negedge clk);
      rst = 0;
   endtask

   task automatic wait_sig(input bit drv, input string tag);
      for (int i = 0; i < 30; i++) begin
         if ((drv ? o_driveNext : o_free) === 1'b1) return;
         go(0, 0, 0);
      end
      chk(tag, drv ? o_driveNext : o_free, 1);
   endtask

   task automatic single_token(input string p);
      go(1, 8'ha5, 0);
      chk({p, "_fire0"}, o_fire, 4'b0001);
      chk({p, "_cnt1"}, o_count, 1);
      go(0, 0, 0);
      chk({p, "_fire1"}, o_fire, 4'b0010);
      chk({p, "_free"}, o_free, 1);
      go(0, 0, 0);
      chk({p, "_fire2"}, o_fire, 4'b0100);
      chk({p, "_free_once"}, o_free, 0);
      go(0, 0, 0);
      chk({p, "_fire3"}, o_fire, 4'b1000);
      chk({p, "_drv_c4"}, o_driveNext, 0);
      go(0, 0, 0);
      chk({p, "_drv_c5"}, o_driveNext, 0);
      go(0, 0, 0);
      chk({p, "_drv_c6"}, o_driveNext, 1);
      chk({p, "_data"}, o_data, 8'ha5);
      chk({p, "_cnt6"}, o_count, 1);
      go(0, 0, 0);
      chk({p, "_drv_c7"}, o_driveNext, 0);
      go(0, 0, 0);
      go(0, 0, 1);
      chk({p, "_cnt9"}, o_count, 0);
      chk({p, "_unf"}, o_underflow, 0);
   endtask

   initial begin
      int n;
      bit can, pend, dv, fr;
      logic [7:0] v;
      @(negedge clk);
      do_reset();
      chk("rst_fire", o_fire, 0);
      chk("rst_cnt", o_count, 0);
      chk("rst_flags", {o_free, o_driveNext, o_overflow, o_underflow}, 0);
      single_token("single");

      do_reset();
      for (int i = 0; i < 4; i++) begin
         go(1, vals[i], 0);
         if (i < 3) begin
            wait_sig(0, "fill_free_timeout");
            go(0, 0, 0);
         end
      end
      for (int i = 0; i < 8; i++) begin
         go(0, 0, 0);
         chk("fill_no_free", o_free, 0);
      end
      chk("fill_cnt4", o_count, 4);
      for (int i = 0; i < 4; i++) begin
         if (i > 0) wait_sig(1, "drain_drv_timeout");
         chk("drain_data", o_data, vals[i]);
         go(0, 0, 1);
      end
      chk("drain_cnt0", o_count, 0);

      do_reset();
      go(1, 8'h01, 0);
      go(1, 8'h02, 0);
      chk("ovf_flag", o_overflow, 1);
      chk("ovf_cnt", o_count, 1);
      wait_sig(1, "ovf_drv_timeout");
      chk("ovf_data", o_data, 8'h01);
      go(0, 0, 1);
      n = 0;
      for (int i = 0; i < 12; i++) begin
         go(0, 0, 0);
         n += int'(o_driveNext);
      end
      chk("ovf_extra_tokens", n, 0);
      chk("ovf_cnt_end", o_count, 0);
      chk("ovf_sticky", o_overflow, 1);

      do_reset();
      go(0, 0, 0);
      go(0, 0, 0);
      go(0, 0, 0);
      go(0, 0, 1);
      chk("unf_empty_flag", o_underflow, 1);
      chk("unf_empty_cnt", o_count, 0);
      do_reset();
      chk("unf_cleared", o_underflow, 0);
      go(1, 8'h77, 0);
      go(0, 0, 0);
      go(0, 0, 0);
      go(0, 0, 0);
      go(0, 0, 1);
      chk("unf_wait_flag", o_underflow, 1);
      chk("unf_wait_cnt", o_count, 1);
      chk("unf_wait_drv_c5", o_driveNext, 0);
      go(0, 0, 0);
      chk("unf_wait_drv_c6", o_driveNext, 1);
      chk("unf_wait_data", o_data, 8'h77);
      go(0, 0, 1);
      chk("unf_wait_cnt_end", o_count, 0);

      do_reset();
      for (int i = 0; i < 3; i++) begin
         go(1, vals[i], 0);
         if (i < 2) begin
            wait_sig(0, "mid_free_timeout");
            go(0, 0, 0);
         end
      end
      chk("mid_cnt3", o_count, 3);
      do_reset();
      chk("mid_fire", o_fire, 0);
      chk("mid_cnt", o_count, 0);
      chk("mid_data", o_data, 0);
      chk("mid_flags", {o_free, o_driveNext, o_overflow, o_underflow}, 0);
      n = 0;
      for (int i = 0; i < 8; i++) begin
         n += int'(o_free) + int'(o_driveNext);
         go(0, 0, 0);
      end
      chk("mid_no_pulses", n, 0);
      single_token("post_rst");

      do_reset();
      d1 = 1;
      v1 = 8'h5c;
      go(0, 0, 0);
      d1 = 0;
      chk("deg_fire", g_fire, 1);
      chk("deg_drv", g_drv, 1);
      chk("deg_data", g_data, 8'h5c);
      chk("deg_cnt1", g_count, 1);
      f1 = 1;
      go(0, 0, 0);
      f1 = 0;
      chk("deg_free", g_free, 1);
      chk("deg_cnt0", g_count, 0);
      chk("deg_unf", g_unf, 0);

      do_reset();
      q.delete();
      can = 1;
      pend = 0;
      for (int c = 0; c < 600; c++) begin
         chk("rnd_count", o_count, q.size());
         if (o_free) can = 1;
         if (o_driveNext) begin
            pend = 1;
            chk("rnd_offer_nonempty", q.size() > 0, 1);
         end
         dv = (c < 450) && can && ($urandom_range(0, 2) == 0);
         fr = pend && ($urandom_range(0, 1) == 1);
         v = 8'($urandom);
         if (fr && q.size() > 0) begin
            chk("rnd_data", o_data, q[0]);
            void'(q.pop_front());
            pend = 0;
         end
         if (dv) begin
            q.push_back(v);
            can = 0;
         end
         go(dv, v, fr);
      end
      chk("rnd_drained", q.size(), 0);
      chk("rnd_ovf", o_overflow, 0);
      chk("rnd_unf", o_underflow, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
